// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART transmit arbiter.
//            - One-hot FSM state encoding.
//            - Default frame reservation derived from the transmitter timing.
//            - Default frame counter width.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // One-hot FSM state encoding.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_SEND = 3'b010,
        S_WAIT = 3'b100
    } state_t;

    // Transmitter timing at 100 MHz.
    localparam int C_BIT_CYC     = 694;   // clocks per start/data bit
    localparam int C_STOP_CYC    = 1387;  // clocks spent in the stop period
    localparam int C_DATA_SLOTS  = 9;     // bit slots at C_BIT_CYC per frame
    localparam int C_FRAME_MARGN = 6;     // slack beyond the transmitter frame

    // Clocks reserved per frame:
    // 1 start cycle + 9*694 data cycles + 1387 stop cycles + margin = 7640.
    localparam int C_FRAME_CYC = 1 + C_DATA_SLOTS * C_BIT_CYC + C_STOP_CYC
                                 + C_FRAME_MARGN;

    // Frame counter width; 2**13 = 8192 > 7640.
    localparam int C_CNT_W = 13;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin request picker. Scans the request
//            vector upward from the priority pointer, wrapping around, and
//            returns the first pending requester. The pointer itself is
//            owned and updated by the parent.
// Ports    : req_i      - request vector
//            ptr_i      - index of the highest-priority requester
//            gnt_o      - one-hot grant (all zero when nothing is pending)
//            gnt_idx_o  - encoded index of the grant
//            any_o      - at least one request is pending
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int P_NUM_REQ = 2
) (
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [1:0]           ptr_i,
    output logic [P_NUM_REQ-1:0] gnt_o,
    output logic [1:0]           gnt_idx_o,
    output logic                 any_o
);

    int   w_idx;
    logic w_found;

    assign any_o = |req_i;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            w_idx = (int'(ptr_i) + k) % P_NUM_REQ;
            if (!w_found && req_i[w_idx]) begin
                w_found       = 1'b1;
                gnt_o[w_idx]  = 1'b1;
                gnt_idx_o     = 2'(w_idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between P_NUM_REQ byte requesters.
//            Grants one requester at a time in round-robin order, sends a
//            one-cycle start pulse with the captured byte, then blocks new
//            grants for the rest of the reserved frame time, because the
//            transmitter has no busy indication of its own.
// Ports    : CLK_100M           - system clock
//            SYS_RST_N          - asynchronous active-low reset
//            TX_EN              - allows new grants (a running frame completes)
//            REQ_VALID          - per-requester byte pending
//            REQ_DATA           - byte i at bits [8i+7:8i]
//            REQ_ACK            - one-cycle pulse, byte i has been taken
//            UART_ENC_START_OUT - transmitter start pulse
//            UART_ENC_DATA      - byte to the transmitter, held until next grant
//            TX_BUSY            - FSM not idle
//            GRANT_ID           - index of the last granted requester
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int P_NUM_REQ   = 2,            // legal range 2..4
    parameter int P_FRAME_CYC = C_FRAME_CYC,  // must be >= 7634 with the real transmitter
    parameter int P_CNT_W     = C_CNT_W       // 2**P_CNT_W must exceed P_FRAME_CYC
) (
    input  logic                   CLK_100M,
    input  logic                   SYS_RST_N,
    input  logic                   TX_EN,
    input  logic [P_NUM_REQ-1:0]   REQ_VALID,
    input  logic [8*P_NUM_REQ-1:0] REQ_DATA,
    output logic [P_NUM_REQ-1:0]   REQ_ACK,
    output logic                   UART_ENC_START_OUT,
    output logic [7:0]             UART_ENC_DATA,
    output logic                   TX_BUSY,
    output logic [1:0]             GRANT_ID
);

    localparam logic [P_CNT_W-1:0] C_CNT_LAST = P_CNT_W'(P_FRAME_CYC - 2);
    localparam logic [1:0]         C_PTR_LAST = 2'(P_NUM_REQ - 1);

    state_t                 state_q, state_d;
    logic [P_CNT_W-1:0]     cnt_q,   cnt_d;
    logic [1:0]             ptr_q,   ptr_d;
    logic [7:0]             data_q,  data_d;
    logic [1:0]             gid_q,   gid_d;
    logic [P_NUM_REQ-1:0]   ack_q,   ack_d;
    logic                   start_q, start_d;

    logic [P_NUM_REQ-1:0]   w_gnt;
    logic [1:0]             w_gnt_idx;
    logic                   w_any;

    rr_arbiter #(
        .P_NUM_REQ (P_NUM_REQ)
    ) u_rr_arbiter (
        .req_i     (REQ_VALID),
        .ptr_i     (ptr_q),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx),
        .any_o     (w_any)
    );

    always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        ack_d   = '0;      // ACK and START are single-cycle pulses
        start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (TX_EN && w_any) begin
                    data_d  = REQ_DATA[8*int'(w_gnt_idx) +: 8];
                    gid_d   = w_gnt_idx;
                    ack_d   = w_gnt;
                    start_d = 1'b1;
                    // Granted requester drops to lowest priority.
                    ptr_d   = (w_gnt_idx == C_PTR_LAST) ? 2'd0 : w_gnt_idx + 2'd1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // SEND (1 cycle) + WAIT (P_FRAME_CYC-1 cycles) covers the frame.
                if (cnt_q == C_CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + P_CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign REQ_ACK            = ack_q;
    assign UART_ENC_START_OUT = start_q;
    assign UART_ENC_DATA      = data_q;
    assign GRANT_ID           = gid_q;
    assign TX_BUSY            = (state_q != S_IDLE);

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. A frame-level reference
//            model predicts every output each cycle; directed sequences cover
//            reset, single request latency, round-robin fairness, TX_EN gating
//            and asynchronous reset mid-frame, followed by random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N = 2;
    localparam int P = 16;
    localparam int W = 5;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           tx_en;
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   REQ_ACK;
    logic           UART_ENC_START_OUT;
    logic [7:0]     UART_ENC_DATA;
    logic           TX_BUSY;
    logic [1:0]     GRANT_ID;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .P_NUM_REQ   (N),
        .P_FRAME_CYC (P),
        .P_CNT_W     (W)
    ) dut (
        .CLK_100M           (clk),
        .SYS_RST_N          (rst_n),
        .TX_EN              (tx_en),
        .REQ_VALID          (valid),
        .REQ_DATA           (data),
        .REQ_ACK            (REQ_ACK),
        .UART_ENC_START_OUT (UART_ENC_START_OUT),
        .UART_ENC_DATA      (UART_ENC_DATA),
        .TX_BUSY            (TX_BUSY),
        .GRANT_ID           (GRANT_ID)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // ---------------- reference model (frame-level) ----------------
    // m_busy = number of upcoming cycles still occupied by the current frame.
    int           m_busy;
    int           m_ptr;
    logic [7:0]   m_data;
    logic [1:0]   m_gid;
    logic [N-1:0] m_ack;
    logic         m_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_data = '0; m_gid = '0; m_ack = '0; m_start = 1'b0;
        end else begin
            m_ack   = '0;
            m_start = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (tx_en && (|valid)) begin
                int  g;
                bit  hit;
                hit = 0;
                g   = 0;
                for (int k = 0; k < N; k++) begin
                    if (!hit && valid[(m_ptr + k) % N]) begin
                        hit = 1;
                        g   = (m_ptr + k) % N;
                    end
                end
                m_data   = data[8*g +: 8];
                m_gid    = 2'(g);
                m_ack[g] = 1'b1;
                m_start  = 1'b1;
                m_ptr    = (g + 1) % N;
                m_busy   = P;
            end
        end
    end

    always @(negedge clk) begin
        check("ack",   32'(REQ_ACK),            32'(m_ack));
        check("start", 32'(UART_ENC_START_OUT), 32'(m_start));
        check("data",  32'(UART_ENC_DATA),      32'(m_data));
        check("busy",  32'(TX_BUSY),            32'(m_busy > 0));
        check("gid",   32'(GRANT_ID),           32'(m_gid));
    end

    // ---------------- helpers ----------------
    task automatic wait_start(input int budget, output int c);
        int i;
        c = -1;
        i = 0;
        while (c < 0 && i < budget) begin
            @(negedge clk);
            if (UART_ENC_START_OUT) c = cyc;
            i++;
        end
        if (c < 0) check("start_timeout", 32'(UART_ENC_START_OUT), 32'd1);
    endtask

    // Counts further negedges with TX_BUSY high until it falls.
    task automatic count_busy_rest(output int nb);
        bit done;
        nb   = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (TX_BUSY) nb++;
            else done = 1;
        end
        if (!done) check("busy_timeout", 32'(TX_BUSY), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, prev, nb, starts;
        tx_en = 1'b1;
        valid = '0;
        data  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(TX_BUSY), 32'd0);
        check("rst_ack",   32'(REQ_ACK), 32'd0);
        check("rst_start", 32'(UART_ENC_START_OUT), 32'd0);
        check("rst_data",  32'(UART_ENC_DATA), 32'd0);
        check("rst_gid",   32'(GRANT_ID), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(TX_BUSY), 32'd0);

        // Single request.
        valid = 2'b01;
        data[7:0] = 8'hA5;
        t0 = cyc;
        wait_start(5, t1);
        check("single_lat",  32'(t1 - t0), 32'd1);
        check("single_ack",  32'(REQ_ACK), 32'b01);
        check("single_data", 32'(UART_ENC_DATA), 32'hA5);
        valid = '0;
        count_busy_rest(nb);
        check("single_busy_len", 32'(nb + 1), 32'(P));

        // Fairness from a fresh pointer.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 2'b11;
        data  = 16'h2211;
        prev  = -1;
        for (int k = 0; k < 4; k++) begin
            wait_start(40, t1);
            check("rr_gid",  32'(GRANT_ID), 32'(k % 2));
            check("rr_data", 32'(UART_ENC_DATA), (k % 2) ? 32'h22 : 32'h11);
            if (prev >= 0) check("rr_gap", 32'(t1 - prev), 32'(P + 1));
            prev = t1;
        end
        valid = '0;
        count_busy_rest(nb);

        // TX_EN dropped 5 cycles into WAIT.
        @(negedge clk);
        valid = 2'b01;
        data[7:0] = 8'h33;
        wait_start(5, t1);
        repeat (5) @(negedge clk);
        tx_en = 1'b0;
        count_busy_rest(nb);
        check("gate_busy_len", 32'(nb + 6), 32'(P));
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (UART_ENC_START_OUT) starts++;
        end
        check("gate_nostart", 32'(starts), 32'd0);
        tx_en = 1'b1;
        t0 = cyc;
        wait_start(3, t1);
        check("gate_lat", 32'(t1 - t0), 32'd1);

        // Asynchronous reset at counter == 7 in WAIT.
        repeat (8) @(negedge clk);
        valid = 2'b11;
        data  = 16'h4433;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(TX_BUSY), 32'd0);
        check("arst_data",  32'(UART_ENC_DATA), 32'd0);
        check("arst_start", 32'(UART_ENC_START_OUT), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(3, t1);
        check("arst_gid",  32'(GRANT_ID), 32'd0);
        check("arst_data2", 32'(UART_ENC_DATA), 32'h33);
        valid = '0;

        // Random traffic obeying the valid/ack handshake.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (valid[i] && REQ_ACK[i]) begin
                    if ($urandom_range(1, 0) == 1) valid[i] = 1'b0;
                    else data[8*i +: 8] = 8'($urandom);
                end else if (!valid[i] && $urandom_range(9, 0) < 3) begin
                    valid[i] = 1'b1;
                    data[8*i +: 8] = 8'($urandom);
                end
            end
            if ($urandom_range(99, 0) < 3) tx_en = ~tx_en;
            if ($urandom_range(999, 0) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
